maxadc_trigger: RTL and testbench

- Downstream consumer of the synchronized 8-bit MAX19506 sample stream in the main_clk domain.
- Implements a level/edge trigger with hysteresis and pre-/post-trigger sample counting.
- Emits a write stream (wr_en/wr_data/wr_trig) to the capture ring buffer, plus capture status.
- Sits between the ADC sync stage and the sample-buffer write port.

---
 rtl/maxadc_pkg.sv | 20 ++
 rtl/maxadc_trig_detect.sv | 51 +++++
 rtl/maxadc_trigger.sv | 220 ++++++++++++++++++++++
 tb/tb_maxadc_trigger.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxadc_pkg.sv
// Shared definitions for the MAX19506 trigger/capture front end.
package maxadc_pkg;

  localparam int MAXADC_DATA_W = 8;
  localparam int MAXADC_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRETRIG = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_DONE    = 3'd4
  } maxadc_state_e;

  // True while a capture is in progress (samples are being written).
  function automatic logic state_is_busy(input maxadc_state_e st);
    return (st == ST_PRETRIG) || (st == ST_ARMED) || (st == ST_POST);
  endfunction

endpackage

// File: rtl/maxadc_trig_detect.sv
// Edge detector with hysteresis: a sample must first leave the band on the
// far side of the threshold (primed) before a crossing counts as an edge.
module maxadc_trig_detect
  import maxadc_pkg::*;
#(
  parameter int DATA_W = MAXADC_DATA_W
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] trig_hyst,
  input  logic              trig_rising,
  output logic              edge_det
);

  logic [DATA_W-1:0] lo_th;
  logic [DATA_W-1:0] hi_th;
  logic [DATA_W:0]   hi_sum;
  logic              prime_zone;
  logic              cross_zone;
  logic              primed_reg;

  // Thresholds saturate instead of wrapping so a wide band near the rails
  // simply makes priming impossible rather than aliasing to the other end.
  assign lo_th  = (trig_level >= trig_hyst) ? (trig_level - trig_hyst) : '0;
  assign hi_sum = {1'b0, trig_level} + {1'b0, trig_hyst};
  assign hi_th  = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];

  assign prime_zone = trig_rising ? (s1_data < lo_th) : (s1_data > hi_th);
  assign cross_zone = trig_rising ? (s1_data >= trig_level) : (s1_data <= trig_level);
  assign edge_det   = s1_en && primed_reg && cross_zone;

  // Primed flag: set in the far zone, consumed by an edge, cleared on demand.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_reg <= 1'b0;
    end else if (clear) begin
      primed_reg <= 1'b0;
    end else if (s1_en) begin
      if (edge_det) begin
        primed_reg <= 1'b0;
      end else if (prime_zone) begin
        primed_reg <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/maxadc_trigger.sv
// Level/edge trigger with pre/post sample counting that feeds the capture
// ring buffer. Samples are registered once (stage 1), then the FSM decides
// whether to write them, so data reaches wr_data two cycles after raw_adc.
module maxadc_trigger
  import maxadc_pkg::*;
#(
  parameter int DATA_W = MAXADC_DATA_W,
  parameter int CNT_W  = MAXADC_CNT_W
) (
  input  logic              main_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] raw_adc,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] trig_hyst,
  input  logic              trig_rising,
  input  logic [CNT_W-1:0]  pre_count,
  input  logic [CNT_W-1:0]  post_count,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_trig,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  // Stage 1 sample register
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_en_reg;

  // Configuration captured at arm time
  logic [DATA_W-1:0] level_reg;
  logic [DATA_W-1:0] hyst_reg;
  logic              rising_reg;
  logic [CNT_W-1:0]  pre_reg;
  logic [CNT_W-1:0]  post_reg;

  // Control state
  maxadc_state_e     state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic              force_pend_reg, force_pend_next;
  logic              triggered_reg, triggered_next;

  // Registered outputs
  logic              wr_en_reg, wr_en_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              wr_trig_reg, wr_trig_next;
  logic              busy_reg;
  logic              done_reg;

  logic              idle_like;
  logic              arm_accept;
  logic              det_clear;
  logic              det_edge;

  assign idle_like  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  assign arm_accept = arm && !abort && idle_like;
  assign det_clear  = arm_accept || abort || idle_like;
  assign cnt_inc    = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};

  maxadc_trig_detect #(
    .DATA_W(DATA_W)
  ) u_detect (
    .main_clk   (main_clk),
    .rst_n      (rst_n),
    .s1_data    (s1_data_reg),
    .s1_en      (s1_en_reg),
    .clear      (det_clear),
    .trig_level (level_reg),
    .trig_hyst  (hyst_reg),
    .trig_rising(rising_reg),
    .edge_det   (det_edge)
  );

  // Stage 1: register the incoming sample and its qualifier.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_reg <= '0;
      s1_en_reg   <= 1'b0;
    end else begin
      s1_data_reg <= raw_adc;
      s1_en_reg   <= sample_en;
    end
  end

  // Latch trigger configuration only when an arm is accepted.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg  <= '0;
      hyst_reg   <= '0;
      rising_reg <= 1'b0;
      pre_reg    <= '0;
      post_reg   <= '0;
    end else if (arm_accept) begin
      level_reg  <= trig_level;
      hyst_reg   <= trig_hyst;
      rising_reg <= trig_rising;
      pre_reg    <= pre_count;
      post_reg   <= post_count;
    end
  end

  // Capture FSM: next state, counters, pending force and write decisions.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    force_pend_next = force_pend_reg;
    triggered_next  = triggered_reg;
    wr_en_next      = 1'b0;
    wr_trig_next    = 1'b0;
    wr_data_next    = wr_data_reg;

    if (abort) begin
      state_next      = ST_IDLE;
      cnt_next        = '0;
      force_pend_next = 1'b0;
      triggered_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          force_pend_next = 1'b0;
          if (arm) begin
            triggered_next = 1'b0;
            cnt_next       = '0;
            state_next     = (pre_count == '0) ? ST_ARMED : ST_PRETRIG;
          end
        end

        ST_PRETRIG: begin
          if (force_trig) begin
            force_pend_next = 1'b1;
          end
          if (s1_en_reg) begin
            wr_en_next   = 1'b1;
            wr_data_next = s1_data_reg;
            if (cnt_inc == pre_reg) begin
              cnt_next   = '0;
              state_next = ST_ARMED;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end

        ST_ARMED: begin
          if (force_trig) begin
            force_pend_next = 1'b1;
          end
          if (s1_en_reg) begin
            wr_en_next   = 1'b1;
            wr_data_next = s1_data_reg;
            // A force requested earlier is served by the first sample here.
            if (det_edge || force_pend_reg) begin
              wr_trig_next    = 1'b1;
              triggered_next  = 1'b1;
              cnt_next        = '0;
              force_pend_next = 1'b0;
              state_next      = (post_reg == '0) ? ST_DONE : ST_POST;
            end
          end
        end

        ST_POST: begin
          force_pend_next = 1'b0;
          if (s1_en_reg) begin
            wr_en_next   = 1'b1;
            wr_data_next = s1_data_reg;
            if (cnt_inc == post_reg) begin
              cnt_next   = '0;
              state_next = ST_DONE;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      force_pend_reg <= 1'b0;
      triggered_reg  <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= '0;
      wr_trig_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      force_pend_reg <= force_pend_next;
      triggered_reg  <= triggered_next;
      wr_en_reg      <= wr_en_next;
      wr_data_reg    <= wr_data_next;
      wr_trig_reg    <= wr_trig_next;
      busy_reg       <= state_is_busy(state_next);
      done_reg       <= (state_next == ST_DONE);
    end
  end

  assign wr_en     = wr_en_reg;
  assign wr_data   = wr_data_reg;
  assign wr_trig   = wr_trig_reg;
  assign busy      = busy_reg;
  assign triggered = triggered_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_maxadc_trigger.sv
// Directed bench for maxadc_trigger: one task per scenario, writes are
// collected by a monitor and compared with hand-derived sequences.
module tb_maxadc_trigger;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              main_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] raw_adc = '0;
  logic              sample_en = 1'b0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              force_trig = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic [DATA_W-1:0] trig_hyst = '0;
  logic              trig_rising = 1'b1;
  logic [CNT_W-1:0]  pre_count = '0;
  logic [CNT_W-1:0]  post_count = '0;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_trig;
  logic              busy;
  logic              triggered;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [7:0] wq[$];
  logic       tq[$];
  logic [7:0] exp_d[$];
  int         exp_ti;

  always #5 main_clk = ~main_clk;

  maxadc_trigger #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .main_clk   (main_clk),
    .rst_n      (rst_n),
    .raw_adc    (raw_adc),
    .sample_en  (sample_en),
    .arm        (arm),
    .abort      (abort),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_hyst  (trig_hyst),
    .trig_rising(trig_rising),
    .pre_count  (pre_count),
    .post_count (post_count),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_trig    (wr_trig),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  // Record every buffer write, one line each.
  always @(negedge main_clk) begin
    if (wr_en === 1'b1) begin
      wq.push_back(wr_data);
      tq.push_back(wr_trig);
      $display("  wr data=%0d trig=%0d t=%0t", wr_data, wr_trig, $time);
    end
  end

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic en);
    raw_adc   = d;
    sample_en = en;
    tick();
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_arm(input logic [7:0] lvl, input logic [7:0] hy, input logic rise,
                        input logic [15:0] pre, input logic [15:0] post);
    trig_level  = lvl;
    trig_hyst   = hy;
    trig_rising = rise;
    pre_count   = pre;
    post_count  = post;
    sample_en   = 1'b0;
    arm         = 1'b1;
    tick();
    arm = 1'b0;
    wq.delete();
    tq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({wr_en, wr_data, wr_trig, busy, triggered, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0d data=%0d trig=%0d busy=%0d trg=%0d done=%0d want all 0",
               wr_en, wr_data, wr_trig, busy, triggered, done);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0d wr_en=%0d want 0 0", busy, wr_en);
    end
  endtask

  task automatic test_basic_rising();
    logic [7:0] s[9];
    s = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160};
    do_arm(8'd128, 8'd10, 1'b1, 16'd4, 16'd3);
    for (int i = 0; i < 9; i++) begin
      drive(s[i], 1'b1);
      if (i == 3) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy: got %0d want 1", busy);
        end
      end
      if (i == 6) begin
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 8'd130 || wr_trig !== 1'b1) begin
          errors++;
          $display("FAIL basic_latency: got en=%0d data=%0d trig=%0d want 1 130 1", wr_en, wr_data, wr_trig);
        end
      end
    end
    idle(1);
    checks++;
    if (done !== 1'b1 || wr_data !== 8'd160) begin
      errors++;
      $display("FAIL basic_done_time: got done=%0d data=%0d want 1 160", done, wr_data);
    end
    idle(2);
    checks++;
    if (done !== 1'b1 || triggered !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: got done=%0d trg=%0d busy=%0d en=%0d want 1 1 0 0", done, triggered, busy, wr_en);
    end
    exp_d = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160};
    exp_ti = 5;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL basic_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
  endtask

  task automatic test_hysteresis();
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd1);
    drive(8'd125, 1'b1);
    drive(8'd130, 1'b1);
    drive(8'd125, 1'b1);
    drive(8'd130, 1'b1);
    idle(2);
    checks++;
    if (triggered !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hyst_reject: got trg=%0d busy=%0d want 0 1", triggered, busy);
    end
    drive(8'd110, 1'b1);
    drive(8'd130, 1'b1);
    drive(8'd140, 1'b1);
    idle(2);
    checks++;
    if (triggered !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL hyst_done: got trg=%0d done=%0d want 1 1", triggered, done);
    end
    exp_d = '{8'd125, 8'd130, 8'd125, 8'd130, 8'd110, 8'd130, 8'd140};
    exp_ti = 5;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL hyst_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL hyst_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
  endtask

  task automatic test_falling_force();
    do_arm(8'd250, 8'd20, 1'b0, 16'd1, 16'd2);
    drive(8'd255, 1'b1);
    drive(8'd200, 1'b1);
    drive(8'd255, 1'b1);
    drive(8'd100, 1'b1);
    idle(2);
    checks++;
    if (triggered !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fall_saturate: got trg=%0d busy=%0d want 0 1", triggered, busy);
    end
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    drive(8'd77, 1'b1);
    drive(8'd78, 1'b1);
    drive(8'd79, 1'b1);
    idle(2);
    checks++;
    if (triggered !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL fall_done: got trg=%0d done=%0d want 1 1", triggered, done);
    end
    exp_d = '{8'd255, 8'd200, 8'd255, 8'd100, 8'd77, 8'd78, 8'd79};
    exp_ti = 4;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL fall_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL fall_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
  endtask

  task automatic test_zero_counts();
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_armed: got busy=%0d done=%0d want 1 0", busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(8'd50, 1'b1);
      else if (i == 3) drive(8'd200, 1'b1);
      else             drive(8'd255, 1'b0);
    end
    idle(3);
    checks++;
    if (done !== 1'b1 || triggered !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%0d trg=%0d busy=%0d want 1 1 0", done, triggered, busy);
    end
    exp_d = '{8'd50, 8'd200};
    exp_ti = 1;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL zero_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL zero_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
  endtask

  task automatic test_abort_post();
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd5);
    drive(8'd50, 1'b1);
    drive(8'd200, 1'b1);
    drive(8'd50, 1'b1);
    drive(8'd60, 1'b1);
    abort = 1'b1;
    drive(8'd70, 1'b1);
    abort = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL abort_status: got en=%0d busy=%0d done=%0d trg=%0d want 0 0 0 0", wr_en, busy, done, triggered);
    end
    drive(8'd80, 1'b1);
    drive(8'd90, 1'b1);
    idle(2);
    exp_d = '{8'd50, 8'd200, 8'd50};
    exp_ti = 1;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL abort_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL abort_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
    // Restart: the earlier 50 must not leave the detector primed.
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd3);
    drive(8'd130, 1'b1);
    drive(8'd140, 1'b1);
    idle(2);
    checks++;
    if (wq.size() !== 2 || triggered !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: got writes=%0d trg=%0d busy=%0d want 2 0 1", wq.size(), triggered, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd2);
    drive(8'd50, 1'b1);
    idle(1);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 8'd50 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got en=%0d data=%0d busy=%0d want 1 50 1", wr_en, wr_data, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || wr_data !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got en=%0d data=%0d busy=%0d want 0 0 0", wr_en, wr_data, busy);
    end
    tick();
    rst_n = 1'b1;
    wq.delete();
    drive(8'd200, 1'b1);
    idle(3);
    checks++;
    if (wq.size() !== 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: got writes=%0d busy=%0d done=%0d want 0 0 0", wq.size(), busy, done);
    end
  endtask

  task automatic test_back_to_back();
    do_arm(8'd128, 8'd10, 1'b1, 16'd2, 16'd1);
    drive(8'd100, 1'b1);
    // Re-arm with a very different config while busy: must be ignored.
    arm         = 1'b1;
    trig_level  = 8'd50;
    trig_hyst   = 8'd0;
    trig_rising = 1'b0;
    pre_count   = 16'd0;
    post_count  = 16'd0;
    drive(8'd110, 1'b1);
    arm = 1'b0;
    drive(8'd130, 1'b1);
    drive(8'd140, 1'b1);
    idle(2);
    checks++;
    if (done !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: got done=%0d trg=%0d want 1 1", done, triggered);
    end
    exp_d = '{8'd100, 8'd110, 8'd130, 8'd140};
    exp_ti = 2;
    checks++;
    if (wq.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes want %0d", wq.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_d[i] || tq[i] !== (i == exp_ti)) begin
        errors++;
        $display("FAIL b2b_wr[%0d]: got %0d/%0d want %0d/%0d", i, wq[i], tq[i], exp_d[i], (i == exp_ti));
      end
    end
    // arm and abort together from DONE: abort wins.
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL armabort: got busy=%0d done=%0d trg=%0d want 0 0 0", busy, done, triggered);
    end
    // force_trig while idle must not carry into the next capture.
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    do_arm(8'd128, 8'd10, 1'b1, 16'd0, 16'd0);
    drive(8'd130, 1'b1);
    drive(8'd130, 1'b1);
    idle(2);
    checks++;
    if (wq.size() !== 2 || triggered !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL idle_force: got writes=%0d trg=%0d busy=%0d want 2 0 1", wq.size(), triggered, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_rising();
    test_hysteresis();
    test_falling_force();
    test_zero_counts();
    test_abort_post();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
